// File: rtl/corr_search_ctrl.sv
// Raster-scan controller for the correlation-score core: issues window positions,
// collects scores and tracks the best match, with a watchdog on a stalled core.
module corr_search_ctrl #(
  parameter int unsigned COORD_W     = 13,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned STEP        = 1,
  parameter bit          BEST_IS_MAX = 1'b0,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iCorr_finished,
  input  logic [SCORE_W-1:0] iCorr_score,
  output logic [COORD_W-1:0] oXstart,
  output logic [COORD_W-1:0] oYstart,
  output logic               oCorr_go,
  output logic               oBusy,
  output logic               oDone,
  output logic               oError,
  output logic [COORD_W-1:0] oBest_x,
  output logic [COORD_W-1:0] oBest_y,
  output logic [SCORE_W-1:0] oBest_score,
  output logic               oBest_valid
);

  localparam int unsigned WD_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned SUM_W = COORD_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_UPDATE, S_ADVANCE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic [SCORE_W-1:0] bs_q, bs_d, score_q, score_d;
  logic               bv_q, bv_d, err_q, err_d, busy_q, busy_d;
  logic               go_q, go_d, done_q, done_d, fin_dly_q, fin_dly_d;
  logic [WD_W-1:0]    wd_q, wd_d;

  logic               fin_edge, wd_hit, x_fits, y_fits, better, replace;
  logic [SUM_W-1:0]   x_sum, y_sum;

  // Sums carry one extra bit so a step past the top of the coordinate range never wraps.
  assign x_sum    = {1'b0, x_q} + SUM_W'(STEP);
  assign y_sum    = {1'b0, y_q} + SUM_W'(STEP);
  assign x_fits   = (x_sum <= SUM_W'(X_MAX));
  assign y_fits   = (y_sum <= SUM_W'(Y_MAX));
  assign fin_edge = iCorr_finished & ~fin_dly_q;
  assign wd_hit   = (wd_q == WD_W'(TIMEOUT - 1));
  assign better   = BEST_IS_MAX ? (score_q > bs_q) : (score_q < bs_q);
  assign replace  = ~bv_q | better;

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (iStart) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (fin_edge)    state_d = S_UPDATE;
        else if (wd_hit) state_d = S_DONE;
      end
      S_UPDATE:  state_d = S_ADVANCE;
      S_ADVANCE: state_d = (x_fits || y_fits) ? S_ISSUE : S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; strobes are registered from the next state
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    bx_d      = bx_q;
    by_d      = by_q;
    bs_d      = bs_q;
    bv_d      = bv_q;
    err_d     = err_q;
    busy_d    = busy_q;
    score_d   = score_q;
    wd_d      = wd_q;
    fin_dly_d = iCorr_finished;
    go_d      = (state_d == S_ISSUE);
    done_d    = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          x_d    = COORD_W'(X_MIN);
          y_d    = COORD_W'(Y_MIN);
          bv_d   = 1'b0;
          err_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      S_ISSUE: wd_d = '0;
      S_WAIT: begin
        if (fin_edge)    score_d = iCorr_score;
        else if (wd_hit) err_d   = 1'b1;
        else             wd_d    = wd_q + WD_W'(1);
      end
      S_UPDATE: begin
        if (replace) begin
          bx_d = x_q;
          by_d = y_q;
          bs_d = score_q;
          bv_d = 1'b1;
        end
      end
      S_ADVANCE: begin
        if (x_fits) begin
          x_d = x_sum[COORD_W-1:0];
        end else if (y_fits) begin
          x_d = COORD_W'(X_MIN);
          y_d = y_sum[COORD_W-1:0];
        end
      end
      S_DONE:  busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_q       <= '0;
      y_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
      bs_q      <= '0;
      bv_q      <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      score_q   <= '0;
      wd_q      <= '0;
      fin_dly_q <= 1'b0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      bs_q      <= bs_d;
      bv_q      <= bv_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      score_q   <= score_d;
      wd_q      <= wd_d;
      fin_dly_q <= fin_dly_d;
      go_q      <= go_d;
      done_q    <= done_d;
    end
  end

  assign oXstart     = x_q;
  assign oYstart     = y_q;
  assign oCorr_go    = go_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;
  assign oError      = err_q;
  assign oBest_x     = bx_q;
  assign oBest_y     = by_q;
  assign oBest_score = bs_q;
  assign oBest_valid = bv_q;

endmodule
